first_layer_scheduler: RTL
==========================

FIRST_LAYER_SCHEDULER -- requirements
Module: first_layer_scheduler

Interface
REQ-001 The block SHALL have parameter NPIXEL, default 784, meaning pixels per image (weights per cell).
REQ-002 The block SHALL have parameter COUNT_BIT1, default 10, meaning pixel address width.
REQ-003 The block SHALL have parameter NCELL, default 32, meaning number of first-layer cells sequenced.
REQ-004 The block SHALL have parameter TIMEOUT, default 2048, meaning max wait cycles for completion flags.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 The block SHALL have port start_forward, input, 1, meaning a 1-cycle request for a weighted-sum pass.
REQ-008 The block SHALL have port start_update, input, 1, meaning a 1-cycle request for a weight/bias update pass.
REQ-009 The block SHALL have port pixel_data, input, 1, meaning the binary pixel read at pixel_addr, with 0-cycle read latency.
REQ-010 The block SHALL have port end_state1, input, NCELL, meaning per-cell completion pulses for the forward pass.
REQ-011 The block SHALL have port end_state6, input, NCELL, meaning per-cell completion pulses for the update pass.
REQ-012 The block SHALL have port pixel_addr, output, COUNT_BIT1, meaning the pixel memory address.
REQ-013 The block SHALL have port pixel_multiply, output, 1, meaning the pixel bit broadcast to all cells.
REQ-014 The block SHALL have port start_state1, output, 1, meaning a 1-cycle broadcast forward-start pulse.
REQ-015 The block SHALL have port update_first_layer, output, 1, meaning a 1-cycle broadcast update pulse.
REQ-016 The block SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-017 The block SHALL have port fwd_done, output, 1, meaning a 1-cycle pulse when all cells report end_state1.
REQ-018 The block SHALL have port upd_done, output, 1, meaning a 1-cycle pulse when all cells report end_state6.
REQ-019 The block SHALL have port timeout_err, output, 1, meaning a sticky flag set on a wait timeout.

Function
REQ-020 The FSM SHALL have the states IDLE, FWD_ISSUE, FWD_STREAM, FWD_WAIT, UPD_ISSUE, UPD_WAIT.
REQ-021 In IDLE with start_forward=1, the FSM SHALL go to FWD_ISSUE; otherwise, with start_update=1, it SHALL go to UPD_ISSUE; if both are 1, forward SHALL win and the update request SHALL be dropped.
REQ-022 Start requests arriving outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023 FWD_ISSUE SHALL last 1 cycle, with start_state1=1 and pixel_addr=0, and SHALL clear the per-cell done flags, the wait counter and timeout_err.
REQ-024 FWD_STREAM SHALL last exactly NPIXEL cycles; in cycle k (k=0..NPIXEL-1), pixel_addr SHALL be k.
REQ-025 pixel_multiply SHALL equal pixel_data while in FWD_STREAM and SHALL be 0 otherwise.
REQ-026 After the cycle with pixel_addr=NPIXEL-1, the FSM SHALL enter FWD_WAIT; pixel_addr SHALL hold at NPIXEL-1 until the next FWD_ISSUE.
REQ-027 Per-cell done flags SHALL be sticky: bit i is set by end_state1[i] in any cycle from FWD_STREAM onward, and by end_state6[i] in UPD_WAIT.
REQ-028 In a wait state, when all NCELL flags are set, including flags set in the current cycle, the block SHALL pulse fwd_done or upd_done for 1 cycle and return to IDLE.
REQ-029 UPD_ISSUE SHALL last 1 cycle with update_first_layer=1, clear the flags, counter and timeout_err, then go to UPD_WAIT.
REQ-030 The wait counter SHALL increment each cycle in FWD_WAIT and UPD_WAIT.
REQ-031 If the wait counter reaches TIMEOUT before all flags are set, the block SHALL set timeout_err, SHALL NOT pulse done, and SHALL return to IDLE.
REQ-032 Completion SHALL take priority over timeout in the same cycle.
REQ-033 Completion pulses for an inactive pass, e.g. end_state6 during a forward pass, SHALL be ignored.
REQ-034 Forward latency SHALL be 1 + NPIXEL cycles from the start_state1 pulse to entry of FWD_WAIT.

Reset
REQ-035 While reset=1, the FSM SHALL be in IDLE, all flags and counters SHALL be 0, and every output SHALL be 0, including pixel_addr=0 and timeout_err=0.
REQ-036 Reset asserted mid-pass SHALL abort the pass immediately, with no done pulse and no pending request retained.
REQ-037 After reset deasserts, the block SHALL accept a start request on the first clock edge.

Verification (NCELL=4, NPIXEL=8, TIMEOUT=16)
REQ-038 Forward: pulse start_forward, pixel memory 8'b1010_0110 -> 1 start_state1 pulse, pixel_addr 0..7 on consecutive cycles, pixel_multiply sequence 0,1,1,0,0,1,0,1, and all end_state1 pulsed 3 cycles later -> fwd_done pulse, busy low next cycle.
REQ-039 Staggered end_state1 (cells 0,2 pulse in FWD_STREAM; cells 1,3 pulse 5 cycles into FWD_WAIT) -> fwd_done in the same cycle as the last pulse.
REQ-040 Update: pulse start_update, end_state6=4'b1111 after 10 cycles -> 1 update_first_layer pulse, then upd_done.
REQ-041 Simultaneous start_forward and start_update in IDLE -> forward pass only; start_update pulsed during a pass -> no update after the pass.
REQ-042 Update with cell 3 never done -> timeout_err=1 after 16 wait cycles, no upd_done, IDLE; timeout_err cleared by the next start.
REQ-043 Reset asserted in FWD_STREAM at pixel_addr=4 -> all outputs 0 asynchronously, no fwd_done; a new start_forward after reset runs a full pass.

Source files
------------

// File: rtl/first_layer_scheduler.sv
// First-layer scheduler: sequences the forward (weighted-sum) and update passes
// across NCELL first-layer cells, streams the binary image one pixel per cycle
// and collects per-cell completion pulses with a bounded wait.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for start_forward / start_update
// FWD_ISSUE  | one cycle: broadcast start_state1, clear flags/counter/error
// FWD_STREAM | NPIXEL cycles: pixel_addr walks 0..NPIXEL-1, pixel broadcast
// FWD_WAIT   | collect end_state1 from every cell, bounded by TIMEOUT
// UPD_ISSUE  | one cycle: broadcast update_first_layer, clear flags/counter/error
// UPD_WAIT   | collect end_state6 from every cell, bounded by TIMEOUT
module first_layer_scheduler #(
    parameter int NPIXEL     = 784,
    parameter int COUNT_BIT1 = 10,
    parameter int NCELL      = 32,
    parameter int TIMEOUT    = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_forward,
    input  logic                  start_update,
    input  logic                  pixel_data,
    input  logic [NCELL-1:0]      end_state1,
    input  logic [NCELL-1:0]      end_state6,
    output logic [COUNT_BIT1-1:0] pixel_addr,
    output logic                  pixel_multiply,
    output logic                  start_state1,
    output logic                  update_first_layer,
    output logic                  busy,
    output logic                  fwd_done,
    output logic                  upd_done,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [COUNT_BIT1-1:0] LAST_ADDR = COUNT_BIT1'(NPIXEL - 1);
    localparam logic [CNT_W-1:0]      LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FWD_ISSUE  = 3'd1,
        FWD_STREAM = 3'd2,
        FWD_WAIT   = 3'd3,
        UPD_ISSUE  = 3'd4,
        UPD_WAIT   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNT_BIT1-1:0]   addr_q, addr_d;
    logic [NCELL-1:0]        flags_q, flags_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    terr_q, terr_d;

    logic [NCELL-1:0]        flags_hit;
    logic                    all_done;
    logic                    wait_expired;

    // Sticky flags merged with this cycle's pulses; only the active pass's
    // completion bus is listened to, so a late end_state1 counts the same cycle.
    always_comb begin
        flags_hit = flags_q;
        case (state_q)
            FWD_STREAM, FWD_WAIT: flags_hit = flags_q | end_state1;
            UPD_WAIT:             flags_hit = flags_q | end_state6;
            default:              flags_hit = flags_q;
        endcase
        all_done     = &flags_hit;
        wait_expired = (cnt_q == LAST_WAIT);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion is checked before the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_forward) begin
                    state_d = FWD_ISSUE;
                end else if (start_update) begin
                    state_d = UPD_ISSUE;
                end
            end
            FWD_ISSUE:  state_d = FWD_STREAM;
            FWD_STREAM: if (addr_q == LAST_ADDR) state_d = FWD_WAIT;
            FWD_WAIT:   if (all_done || wait_expired) state_d = IDLE;
            UPD_ISSUE:  state_d = UPD_WAIT;
            UPD_WAIT:   if (all_done || wait_expired) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next values: pixel address, done flags, wait counter, error flag
    always_comb begin
        addr_d  = addr_q;
        flags_d = flags_hit;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                // Address restarts at 0 so FWD_ISSUE already presents pixel 0.
                if (start_forward) addr_d = '0;
            end
            FWD_ISSUE, UPD_ISSUE: begin
                flags_d = '0;
                cnt_d   = '0;
                terr_d  = 1'b0;
            end
            FWD_STREAM: begin
                // Address parks on the last pixel through FWD_WAIT and IDLE.
                if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
            end
            FWD_WAIT, UPD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!all_done && wait_expired) terr_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Outputs decoded from state; pixel path is combinational (0-cycle memory)
    always_comb begin
        pixel_addr         = addr_q;
        timeout_err        = terr_q;
        busy               = (state_q != IDLE);
        start_state1       = (state_q == FWD_ISSUE);
        update_first_layer = (state_q == UPD_ISSUE);
        pixel_multiply     = (state_q == FWD_STREAM) && pixel_data;
        fwd_done           = (state_q == FWD_WAIT) && all_done;
        upd_done           = (state_q == UPD_WAIT) && all_done;
    end

endmodule
